// File: rtl/mips_bus_arbiter.sv
// Two-master bus arbiter for the MIPS CPU memory bus.
// M0 is instruction fetch and M1 is data load/store. One whole transfer is granted at a time,
// with an IDLE arbitration cycle between transfers. A slave that stalls too long forces an abort
// and sets a sticky bus error.
module mips_bus_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  // fetch master
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  // data master
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  // slave side
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  // status
  output logic [1:0]  grant,
  output logic        bus_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e          state_q;
  logic            last_grant_q;  // 1 = M1 owned the most recent grant
  logic [CntW-1:0] cnt_q;
  logic            bus_error_q;

  logic req0, req1, pick_m1, grant_req, timeout_hit;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // M1 wins when alone, under fixed priority, or when M0 was served last
  assign pick_m1 = req1 && (!req0 || (FIXED_PRIORITY != 0) || !last_grant_q);

  assign grant_req   = (state_q == StGrant0) ? req0 : (state_q == StGrant1) ? req1 : 1'b0;
  assign timeout_hit = grant_req && s_waitrequest && (cnt_q == CntMax);

  assign bus_error = bus_error_q;

  // Arbitration FSM, stall counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pick_m1) begin
            state_q      <= StGrant1;
            last_grant_q <= 1'b1;
          end else if (req0) begin
            state_q      <= StGrant0;
            last_grant_q <= 1'b0;
          end
        end
        StGrant0, StGrant1: begin
          // A dropped request is abandoned silently; completion and abort both return to idle
          if (!grant_req || !s_waitrequest) begin
            state_q <= StIdle;
          end else if (timeout_hit) begin
            state_q     <= StIdle;
            bus_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Route the owner's request to the slave and the slave's response back to the owner
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    grant          = 2'b00;
    unique case (state_q)
      StGrant0: begin
        grant          = 2'b01;
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
        if (timeout_hit) begin
          s_read         = 1'b0;
          s_write        = 1'b0;
          m0_waitrequest = 1'b0;
          m0_readdata    = '0;
        end
      end
      StGrant1: begin
        grant          = 2'b10;
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
        if (timeout_hit) begin
          s_read         = 1'b0;
          s_write        = 1'b0;
          m1_waitrequest = 1'b0;
          m1_readdata    = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: cycle table plus timeout, reset and priority sequences.
module tb_mips_bus_arbiter;

  localparam logic [31:0] A0 = 32'hBFC0_0000;
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [3:0]  B0 = 4'b0011;
  localparam logic [31:0] A1 = 32'h0000_1000;
  localparam logic [31:0] D1 = 32'h0221_0000;
  localparam logic [3:0]  B1 = 4'b1111;

  logic        clk, reset;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata, s_readdata;
  logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
  logic [3:0]  m0_byteenable, m1_byteenable;

  logic        m0_waitrequest, m1_waitrequest, s_read, s_write, bus_error;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_s_read, fp_s_write, fp_bus_error;
  logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata;
  logic [3:0]  fp_s_byteenable;
  logic [1:0]  fp_grant;

  int checks = 0;
  int failures = 0;

  mips_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .bus_error(bus_error)
  );

  mips_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(16)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
    .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
    .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(fp_grant), .bus_error(fp_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        m0r, m1r, m1w, swait;
    logic [31:0] srd;
    logic [1:0]  e_grant;
    logic        e_m0_wait, e_m1_wait, e_s_read, e_s_write;
    logic [31:0] e_s_addr, e_s_wdata;
    logic [3:0]  e_s_be;
    logic [31:0] e_m0_rd, e_m1_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m0r, input logic m1r, input logic m1w, input logic swait,
                       input logic [31:0] srd);
    m0_read       = m0r;
    m1_read       = m1r;
    m1_write      = m1w;
    s_waitrequest = swait;
    s_readdata    = srd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Expected-value helpers: bus idle, M0 owns, M1 owns
  function automatic vec_t v_idle(input logic rst, input logic m0r, input logic m1r,
                                  input logic m1w, input logic swait, input logic err);
    vec_t v;
    v = '{rst, m0r, m1r, m1w, swait, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
          32'h0, 32'h0, 4'h0, 32'h0, 32'h0, err};
    return v;
  endfunction

  function automatic vec_t v_g0(input logic m0r, input logic m1r, input logic m1w,
                                input logic swait, input logic [31:0] srd);
    vec_t v;
    v = '{1'b0, m0r, m1r, m1w, swait, srd, 2'b01, swait, 1'b1, m0r, 1'b0,
          A0, D0, B0, srd, 32'h0, 1'b0};
    return v;
  endfunction

  function automatic vec_t v_g1(input logic m0r, input logic m1r, input logic m1w,
                                input logic swait, input logic [31:0] srd);
    vec_t v;
    v = '{1'b0, m0r, m1r, m1w, swait, srd, 2'b10, 1'b1, swait, m1r, m1w,
          A1, D1, B1, 32'h0, srd, 1'b0};
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    m0_address = A0; m0_writedata = D0; m0_byteenable = B0; m0_write = 1'b0;
    m1_address = A1; m1_writedata = D1; m1_byteenable = B1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // M0 read alone with two stall cycles
    vecs.push_back(v_idle(0, 1, 0, 0, 1, 0));
    vecs.push_back(v_g0(1, 0, 0, 1, 32'h0));
    vecs.push_back(v_g0(1, 0, 0, 1, 32'h0));
    vecs.push_back(v_g0(1, 0, 0, 0, 32'h3C03_BFC0));
    vecs.push_back(v_idle(0, 0, 0, 0, 0, 0));
    // Reset, then both masters tie repeatedly: M0, M1, M0, M1 with idle bubbles
    vecs.push_back(v_idle(1, 0, 0, 0, 0, 0));
    vecs.push_back(v_idle(0, 1, 1, 0, 0, 0));
    vecs.push_back(v_g0(1, 1, 0, 0, 32'hAAAA_0000));
    vecs.push_back(v_idle(0, 1, 1, 0, 0, 0));
    vecs.push_back(v_g1(1, 1, 0, 0, 32'h0000_5555));
    vecs.push_back(v_idle(0, 1, 1, 0, 0, 0));
    vecs.push_back(v_g0(1, 1, 0, 0, 32'h0000_1234));
    vecs.push_back(v_idle(0, 1, 1, 0, 0, 0));
    vecs.push_back(v_g1(1, 1, 0, 0, 32'h0000_4321));
    vecs.push_back(v_idle(0, 0, 0, 0, 0, 0));
    // M1 write while M0 also requests
    vecs.push_back(v_idle(0, 0, 0, 1, 1, 0));
    vecs.push_back(v_g1(1, 0, 1, 1, 32'h0));
    vecs.push_back(v_g1(1, 0, 1, 0, 32'h0));
    vecs.push_back(v_idle(0, 1, 0, 0, 0, 0));
    vecs.push_back(v_g0(1, 0, 0, 0, 32'h0F0F_0F0F));
    vecs.push_back(v_idle(0, 0, 0, 0, 0, 0));
    // Granted master drops its request mid-transfer
    vecs.push_back(v_idle(0, 1, 0, 0, 0, 0));
    vecs.push_back(v_g0(0, 0, 0, 1, 32'h0));
    vecs.push_back(v_idle(0, 0, 0, 0, 0, 0));

    // Reset state
    do_reset();
    #1;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("rst m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("rst s_read", 32'(s_read), 32'h0);
    chk("rst s_write", 32'(s_write), 32'h0);
    chk("rst s_addr", s_address, 32'h0);
    chk("rst s_be", 32'(s_byteenable), 32'h0);
    chk("rst bus_error", 32'(bus_error), 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      drive(vecs[i].m0r, vecs[i].m1r, vecs[i].m1w, vecs[i].swait, vecs[i].srd);
      #1;
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("row%0d m0_wait", i), 32'(m0_waitrequest), 32'(vecs[i].e_m0_wait));
      chk($sformatf("row%0d m1_wait", i), 32'(m1_waitrequest), 32'(vecs[i].e_m1_wait));
      chk($sformatf("row%0d s_read", i), 32'(s_read), 32'(vecs[i].e_s_read));
      chk($sformatf("row%0d s_write", i), 32'(s_write), 32'(vecs[i].e_s_write));
      chk($sformatf("row%0d s_addr", i), s_address, vecs[i].e_s_addr);
      chk($sformatf("row%0d s_wdata", i), s_writedata, vecs[i].e_s_wdata);
      chk($sformatf("row%0d s_be", i), 32'(s_byteenable), 32'(vecs[i].e_s_be));
      chk($sformatf("row%0d m0_rd", i), m0_readdata, vecs[i].e_m0_rd);
      chk($sformatf("row%0d m1_rd", i), m1_readdata, vecs[i].e_m1_rd);
      chk($sformatf("row%0d err", i), 32'(bus_error), 32'(vecs[i].e_err));
    end

    // Timeout: slave stuck in waitrequest for 16 granted cycles
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk("to arb grant", 32'(grant), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to c%0d grant", k), 32'(grant), 32'h1);
      chk($sformatf("to c%0d m0_wait", k), 32'(m0_waitrequest), (k == 16) ? 32'h0 : 32'h1);
      chk($sformatf("to c%0d s_read", k), 32'(s_read), (k == 16) ? 32'h0 : 32'h1);
      chk($sformatf("to c%0d err", k), 32'(bus_error), 32'h0);
    end
    chk("to m0_rd zero", m0_readdata, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("to after grant", 32'(grant), 32'h0);
    chk("to after err", 32'(bus_error), 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h600D_600D);
    @(negedge clk);
    #1;
    chk("to good m0_wait", 32'(m0_waitrequest), 32'h0);
    chk("to good m0_rd", m0_readdata, 32'h600D_600D);
    chk("to good err sticky", 32'(bus_error), 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("to idle err sticky", 32'(bus_error), 32'h1);

    // Reset asserted during GRANT1
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    chk("mr grant1", 32'(grant), 32'h2);
    chk("mr s_read", 32'(s_read), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mr post s_read", 32'(s_read), 32'h0);
    chk("mr post s_write", 32'(s_write), 32'h0);
    chk("mr post grant", 32'(grant), 32'h0);
    chk("mr post m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("mr post m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("mr post err", 32'(bus_error), 32'h0);
    @(negedge clk);
    #1;
    chk("mr first tie", 32'(grant), 32'h1);

    // Fixed priority: M1 takes every grant while both request
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      chk($sformatf("fp c%0d grant", k), 32'(fp_grant), (k % 2 == 1) ? 32'h2 : 32'h0);
      chk($sformatf("fp c%0d m0_wait", k), 32'(fp_m0_waitrequest), 32'h1);
      if (k == 1) chk("rr c1 grant", 32'(grant), 32'h1);
      if (k == 3) chk("rr c3 grant", 32'(grant), 32'h2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
